change_dispenser: RTL and testbench
===================================

# change_dispenser

Coin-change payout unit that sits downstream of the vending-machine controller. It accepts a change amount on a request/acknowledge handshake and pays it out greedily as individual coins of 50, 10, 5 and 1 dollars to the coin hopper, one coin per valid/taken handshake. It keeps a per-denomination inventory, accepts refills while idle, and reports any unpaid remainder when inventory runs out.

## Interface
Parameters:
- INIT_50, default 8'd20: coins of 50 loaded on reset.
- INIT_10, default 8'd20: coins of 10 loaded on reset.
- INIT_5, default 8'd20: coins of 5 loaded on reset.
- INIT_1, default 8'd20: coins of 1 loaded on reset.

Ports:
- clk  in  1  the single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- change_req  in  1  request to pay out change_amt; sampled only in IDLE.
- change_amt  in  8  amount to pay out, in dollars.
- change_ack  out  1  one-cycle pulse: the request was accepted.
- busy  out  1  high in every state except IDLE.
- coin_valid  out  1  a coin is presented to the hopper.
- coin_val  out  6  denomination presented (50, 10, 5 or 1); 0 when coin_valid is low.
- coin_taken  in  1  the hopper has taken the presented coin.
- done  out  1  one-cycle pulse at the end of a payout.
- shortfall  out  8  unpaid remainder of the last payout; held until the next done.
- refill  in  1  add refill_cnt coins to the bin chosen by refill_sel.
- refill_sel  in  2  bin select: 0 = 1, 1 = 5, 2 = 10, 3 = 50.
- refill_cnt  in  8  number of coins to add.
- inv_empty  out  4  per-bin empty flags, same bit order as refill_sel.

## Operation
- Internal registers:
  - remaining: 8 bits.
  - inv_1, inv_5, inv_10, inv_50: 8 bits each.
  - sel_d: the denomination currently presented.
- All outputs are registered.
- State machine IDLE, SELECT, ISSUE, DONE:
  - IDLE: when change_req is high, latch remaining = change_amt, pulse change_ack and go to SELECT. A zero amount follows the same path; SELECT then goes straight to DONE.
  - SELECT: pick the largest denomination d with d <= remaining and inv_d > 0.
    - If one exists, drive coin_val = d and coin_valid = 1, then go to ISSUE.
    - Otherwise load shortfall = remaining, pulse done and go to DONE.
  - ISSUE: hold coin_valid and coin_val stable until coin_taken is sampled high. Then remaining -= d, inv_d -= 1, coin_valid = 0, coin_val = 0, and go to SELECT.
  - DONE: done is high for this single cycle, then return to IDLE. No coin is presented.
- The greedy choice is re-evaluated in every SELECT, so an empty bin falls through to the next smaller denomination.
- Arithmetic never wraps: the inventory counters cannot underflow, because a coin is only presented when its bin is non-zero, and remaining cannot underflow, because d <= remaining.
- Refill:
  - Honoured only in IDLE: inv_sel = min(inv_sel + refill_cnt, 255), saturating.
  - Ignored in every other state.
- Simultaneous refill and change_req in IDLE: both are accepted. The refill is applied on the same edge, and SELECT sees the updated count.
- change_req outside IDLE is ignored. There is no queuing; the requester must hold or re-issue the request.
- coin_taken outside ISSUE is ignored.
- inv_empty[i] = (bin i == 0), registered alongside the counters.

## Timing
- Reset values (rst high, asynchronous):
  - State: IDLE.
  - Outputs: change_ack, busy, coin_valid, coin_val, done, shortfall = 0.
  - Internal: remaining = 0, inventories = INIT_*, inv_empty reflecting INIT_*.
- Reset mid-payout aborts immediately: no done pulse, the coin is withdrawn, and the inventories reload to INIT_*.
- change_req sampled at edge N: change_ack and busy are high after edge N; coin_valid rises after edge N+1.
- coin_taken sampled at edge T: coin_valid falls after edge T, and the next coin is valid after edge T+1. The minimum is 2 cycles per coin.
- After the final take at edge T, done is high after edge T+1 and the block is IDLE (busy = 0) after edge T+2.
- A request with amount 0 at edge N: done is high after edge N+1, with no coin.
- Back-to-back: a new change_req is accepted on the first edge where the state is IDLE.

## Test plan
- Reset with the defaults, request 37 → coins presented in order 10, 10, 10, 5, 1, 1. Then done with shortfall 0, inv_10 = 17, inv_5 = 19, inv_1 = 18.
- Request 66 → coins 50, 10, 5, 1, then shortfall 0. Request 0 → change_ack, then done one cycle later with no coin_valid.
- INIT_50 = INIT_10 = INIT_5 = 0 and INIT_1 = 2, request 4 → coins 1, 1, then done with shortfall 2 and inv_empty = 4'b1111.
- Hold coin_taken low for 5 cycles while coin_valid = 1, coin_val = 10 → both outputs stay stable and the counters stay unchanged. The take then completes normally.
- In IDLE with inv_10 = 20, refill with sel 2, count 250 → inv_10 saturates at 255. A refill pulsed during a payout leaves the counts unchanged.
- Assert rst while coin_valid is high mid-payout → all outputs 0 asynchronously and no done pulse. The inventories return to INIT_*, and a subsequent request of 15 pays out 10, 5.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin-change payout unit: pays an amount as 50/10/5/1 coins over a
// valid/taken handshake, tracking a saturating per-denomination inventory.
module change_dispenser #(
    parameter logic [7:0] INIT_50 = 8'd20,
    parameter logic [7:0] INIT_10 = 8'd20,
    parameter logic [7:0] INIT_5  = 8'd20,
    parameter logic [7:0] INIT_1  = 8'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change_req,
    input  logic [7:0] change_amt,
    output logic       change_ack,
    output logic       busy,
    output logic       coin_valid,
    output logic [5:0] coin_val,
    input  logic       coin_taken,
    output logic       done,
    output logic [7:0] shortfall,
    input  logic       refill,
    input  logic [1:0] refill_sel,
    input  logic [7:0] refill_cnt,
    output logic [3:0] inv_empty
);
    // state  | meaning
    // IDLE   | waiting for a request; refills accepted
    // SELECT | choose the largest affordable, stocked coin
    // ISSUE  | coin presented, waiting for coin_taken
    // DONE   | one-cycle done pulse
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0] state;
    logic [7:0] remaining;
    logic [7:0] inv_1, inv_5, inv_10, inv_50;
    logic [7:0] inv_1_n, inv_5_n, inv_10_n, inv_50_n;
    logic [1:0] sel_d;
    logic       pick_ok;
    logic [1:0] pick_bin;

    function automatic logic [5:0] denom(input logic [1:0] bin);
        case (bin)
            2'd0:    denom = 6'd1;
            2'd1:    denom = 6'd5;
            2'd2:    denom = 6'd10;
            default: denom = 6'd50;
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = s[8] ? 8'hFF : s[7:0];
    endfunction

    always_comb begin
        pick_ok  = 1'b0;
        pick_bin = 2'd0;
        if (remaining >= 8'd50 && inv_50 != 8'd0) begin
            pick_ok  = 1'b1;
            pick_bin = 2'd3;
        end else if (remaining >= 8'd10 && inv_10 != 8'd0) begin
            pick_ok  = 1'b1;
            pick_bin = 2'd2;
        end else if (remaining >= 8'd5 && inv_5 != 8'd0) begin
            pick_ok  = 1'b1;
            pick_bin = 2'd1;
        end else if (remaining >= 8'd1 && inv_1 != 8'd0) begin
            pick_ok  = 1'b1;
            pick_bin = 2'd0;
        end
    end

    // Refill and take are mutually exclusive by state, so one mux per bin suffices.
    always_comb begin
        inv_1_n  = inv_1;
        inv_5_n  = inv_5;
        inv_10_n = inv_10;
        inv_50_n = inv_50;
        if (state == S_IDLE && refill) begin
            case (refill_sel)
                2'd0:    inv_1_n  = sat_add(inv_1, refill_cnt);
                2'd1:    inv_5_n  = sat_add(inv_5, refill_cnt);
                2'd2:    inv_10_n = sat_add(inv_10, refill_cnt);
                default: inv_50_n = sat_add(inv_50, refill_cnt);
            endcase
        end else if (state == S_ISSUE && coin_taken) begin
            case (sel_d)
                2'd0:    inv_1_n  = inv_1 - 8'd1;
                2'd1:    inv_5_n  = inv_5 - 8'd1;
                2'd2:    inv_10_n = inv_10 - 8'd1;
                default: inv_50_n = inv_50 - 8'd1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            remaining  <= 8'd0;
            sel_d      <= 2'd0;
            change_ack <= 1'b0;
            busy       <= 1'b0;
            coin_valid <= 1'b0;
            coin_val   <= 6'd0;
            done       <= 1'b0;
            shortfall  <= 8'd0;
            inv_1      <= INIT_1;
            inv_5      <= INIT_5;
            inv_10     <= INIT_10;
            inv_50     <= INIT_50;
            inv_empty  <= {INIT_50 == 8'd0, INIT_10 == 8'd0, INIT_5 == 8'd0, INIT_1 == 8'd0};
        end else begin
            inv_1      <= inv_1_n;
            inv_5      <= inv_5_n;
            inv_10     <= inv_10_n;
            inv_50     <= inv_50_n;
            inv_empty  <= {inv_50_n == 8'd0, inv_10_n == 8'd0, inv_5_n == 8'd0, inv_1_n == 8'd0};
            change_ack <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (change_req) begin
                        remaining  <= change_amt;
                        change_ack <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (pick_ok) begin
                        sel_d      <= pick_bin;
                        coin_val   <= denom(pick_bin);
                        coin_valid <= 1'b1;
                        state      <= S_ISSUE;
                    end else begin
                        shortfall <= remaining;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (coin_taken) begin
                        remaining  <= remaining - {2'b00, coin_val};
                        coin_valid <= 1'b0;
                        coin_val   <= 6'd0;
                        state      <= S_SELECT;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table, corner sequences and
// randomized payouts against a greedy-change reference model.
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       change_req = 1'b0;
    logic [7:0] change_amt = 8'd0;
    logic       change_ack, busy, coin_valid, done;
    logic [5:0] coin_val;
    logic       coin_taken = 1'b0;
    logic [7:0] shortfall;
    logic       refill = 1'b0;
    logic [1:0] refill_sel = 2'd0;
    logic [7:0] refill_cnt = 8'd0;
    logic [3:0] inv_empty;

    logic       b_req = 1'b0;
    logic [7:0] b_amt = 8'd0;
    logic       b_ack, b_busy, b_valid, b_done;
    logic [5:0] b_val;
    logic       b_taken = 1'b0;
    logic [7:0] b_short;
    logic [3:0] b_empty;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk(clk), .rst(rst), .change_req(change_req), .change_amt(change_amt),
        .change_ack(change_ack), .busy(busy), .coin_valid(coin_valid), .coin_val(coin_val),
        .coin_taken(coin_taken), .done(done), .shortfall(shortfall), .refill(refill),
        .refill_sel(refill_sel), .refill_cnt(refill_cnt), .inv_empty(inv_empty)
    );

    change_dispenser #(.INIT_50(8'd0), .INIT_10(8'd0), .INIT_5(8'd0), .INIT_1(8'd2)) dut2 (
        .clk(clk), .rst(rst), .change_req(b_req), .change_amt(b_amt),
        .change_ack(b_ack), .busy(b_busy), .coin_valid(b_valid), .coin_val(b_val),
        .coin_taken(b_taken), .done(b_done), .shortfall(b_short), .refill(1'b0),
        .refill_sel(2'd0), .refill_cnt(8'd0), .inv_empty(b_empty)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bin index 0..3 holds coins of 1, 5, 10, 50.
    int den[4] = '{1, 5, 10, 50};
    int minv[4];
    int exp_q[$];
    int exp_short;

    typedef struct {
        int amt;
        int first_coin;
        int ncoins;
        int short_amt;
        int inv10;
        int inv5;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input int d);
        case (d)
            1:       return 0;
            5:       return 1;
            10:      return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int get_inv(input int i);
        case (i)
            0:       return int'(dut.inv_1);
            1:       return int'(dut.inv_5);
            2:       return int'(dut.inv_10);
            default: return int'(dut.inv_50);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) minv[i] = 20;
    endtask

    task automatic model_refill(input int sel, input int cnt);
        minv[sel] = (minv[sel] + cnt > 255) ? 255 : minv[sel] + cnt;
    endtask

    // Greedy payout: largest coin first, as many as amount and stock allow.
    task automatic plan(input int amt);
        int rem;
        int stock[4];
        rem = amt;
        for (int i = 0; i < 4; i++) stock[i] = minv[i];
        exp_q.delete();
        for (int i = 3; i >= 0; i--) begin
            while (rem >= den[i] && stock[i] > 0) begin
                exp_q.push_back(den[i]);
                rem -= den[i];
                stock[i]--;
            end
        end
        exp_short = rem;
    endtask

    task automatic check_inventory(input string tag);
        int e;
        for (int i = 0; i < 4; i++) check({tag, "_inv"}, get_inv(i), minv[i]);
        e = 0;
        for (int i = 0; i < 4; i++) if (minv[i] == 0) e |= (1 << i);
        check({tag, "_inv_empty"}, int'(inv_empty), e);
    endtask

    task automatic recover();
        for (int i = 0; i < 600; i++) begin
            if (!busy) break;
            coin_taken = 1'b1;
            step();
        end
        coin_taken = 1'b0;
        if (busy) check("recover_idle", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic payout(input int amt, input int min_stall, input int max_stall,
                          input bit mid_refill, input bit pre_refill, input int rsel,
                          input int rcnt, output int ncoins, output int first_coin);
        int rem;
        int stall;
        int bi;
        bit ok;
        ncoins = 0;
        first_coin = 0;
        if (pre_refill) begin
            refill = 1'b1;
            refill_sel = 2'(rsel);
            refill_cnt = 8'(rcnt);
            model_refill(rsel, rcnt);
        end
        plan(amt);
        rem = amt;
        change_req = 1'b1;
        change_amt = 8'(amt);
        step();
        change_req = 1'b0;
        refill = 1'b0;
        check("ack", int'(change_ack), 1);
        check("busy", int'(busy), 1);
        check("no_coin_at_ack", int'(coin_valid), 0);
        ok = 1'b1;
        for (int k = 0; k < 300 && ok; k++) begin
            step();
            if (exp_q.size() > 0) begin
                check("coin_valid", int'(coin_valid), 1);
                check("coin_val", int'(coin_val), exp_q[0]);
                check("done_early", int'(done), 0);
                if (coin_valid !== 1'b1) begin
                    ok = 1'b0;
                end else begin
                    if (ncoins == 0) first_coin = int'(coin_val);
                    bi = idx_of(exp_q[0]);
                    stall = $urandom_range(max_stall, min_stall);
                    if (mid_refill && stall == 0) stall = 1;
                    for (int s = 0; s < stall; s++) begin
                        if (mid_refill && s == 0) begin
                            refill = 1'b1;
                            refill_sel = 2'($urandom_range(3, 0));
                            refill_cnt = 8'd7;
                        end
                        step();
                        refill = 1'b0;
                        check("stall_valid", int'(coin_valid), 1);
                        check("stall_val", int'(coin_val), exp_q[0]);
                        check("stall_remaining", int'(dut.remaining), rem);
                        check("stall_inv", get_inv(bi), minv[bi]);
                    end
                    coin_taken = 1'b1;
                    step();
                    coin_taken = 1'b0;
                    check("coin_drop", int'(coin_valid), 0);
                    check("coin_val_zero", int'(coin_val), 0);
                    minv[bi]--;
                    rem -= exp_q[0];
                    void'(exp_q.pop_front());
                    ncoins++;
                end
            end else begin
                check("done", int'(done), 1);
                check("shortfall", int'(shortfall), exp_short);
                check("no_coin_at_done", int'(coin_valid), 0);
                step();
                check("done_pulse", int'(done), 0);
                check("idle_busy", int'(busy), 0);
                ok = 1'b0;
            end
        end
        recover();
        check_inventory("post_payout");
    endtask

    vec_t vecs[4];
    int n, fc;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{amt: 37,  first_coin: 10, ncoins: 6, short_amt: 0, inv10: 17, inv5: 19};
        vecs[1] = '{amt: 66,  first_coin: 50, ncoins: 4, short_amt: 0, inv10: 16, inv5: 18};
        vecs[2] = '{amt: 0,   first_coin: 0,  ncoins: 0, short_amt: 0, inv10: 16, inv5: 18};
        vecs[3] = '{amt: 255, first_coin: 50, ncoins: 6, short_amt: 0, inv10: 16, inv5: 17};

        do_reset();
        check("rst_ack", int'(change_ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(coin_valid), 0);
        check("rst_val", int'(coin_val), 0);
        check("rst_done", int'(done), 0);
        check("rst_short", int'(shortfall), 0);
        check("rst_empty", int'(inv_empty), 0);
        check("rst_empty2", int'(b_empty), 4'b1110);
        check_inventory("reset");

        // Sparse inventory: amount 4 with only two 1-coins.
        b_req = 1'b1;
        b_amt = 8'd4;
        step();
        b_req = 1'b0;
        check("b_ack", int'(b_ack), 1);
        for (int c = 0; c < 2; c++) begin
            step();
            check("b_coin_valid", int'(b_valid), 1);
            check("b_coin_val", int'(b_val), 1);
            b_taken = 1'b1;
            step();
            b_taken = 1'b0;
            check("b_coin_drop", int'(b_valid), 0);
        end
        step();
        check("b_done", int'(b_done), 1);
        check("b_shortfall", int'(b_short), 2);
        check("b_empty", int'(b_empty), 4'b1111);
        step();
        check("b_idle", int'(b_busy), 0);

        for (int i = 0; i < 4; i++) begin
            payout(vecs[i].amt, 0, 2, 1'b0, 1'b0, 0, 0, n, fc);
            check("vec_first_coin", fc, vecs[i].first_coin);
            check("vec_ncoins", n, vecs[i].ncoins);
            check("vec_shortfall", int'(shortfall), vecs[i].short_amt);
            check("vec_inv10", int'(dut.inv_10), vecs[i].inv10);
            check("vec_inv5", int'(dut.inv_5), vecs[i].inv5);
        end

        // Long stall on a 10 coin, then saturation refill from fresh stock.
        do_reset();
        payout(10, 5, 5, 1'b0, 1'b0, 0, 0, n, fc);
        check("stall_first", fc, 10);
        do_reset();
        refill = 1'b1;
        refill_sel = 2'd2;
        refill_cnt = 8'd250;
        model_refill(2, 250);
        step();
        refill = 1'b0;
        check("sat_inv10", int'(dut.inv_10), 255);
        check_inventory("sat");
        payout(38, 1, 3, 1'b1, 1'b0, 0, 0, n, fc);

        // Reset while a coin is presented.
        change_req = 1'b1;
        change_amt = 8'd60;
        step();
        change_req = 1'b0;
        step();
        check("pre_rst_valid", int'(coin_valid), 1);
        rst = 1'b1;
        #1;
        check("arst_valid", int'(coin_valid), 0);
        check("arst_val", int'(coin_val), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        model_reset();
        step();
        rst = 1'b0;
        step();
        check("post_rst_done", int'(done), 0);
        check_inventory("post_rst");
        payout(15, 0, 1, 1'b0, 1'b0, 0, 0, n, fc);
        check("rst15_first", fc, 10);
        check("rst15_ncoins", n, 2);

        // Randomized traffic, including refill coincident with a request.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(3, 0) == 0) begin
                refill = 1'b1;
                refill_sel = 2'($urandom_range(3, 0));
                refill_cnt = 8'($urandom_range(40, 0));
                model_refill(int'(refill_sel), int'(refill_cnt));
                step();
                refill = 1'b0;
                check_inventory("rand_refill");
            end
            payout(int'($urandom_range(255, 0)), 0, 3, 1'($urandom_range(1, 0)),
                   ($urandom_range(2, 0) == 0), int'($urandom_range(3, 0)),
                   int'($urandom_range(60, 0)), n, fc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
